// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter and sequencer sharing one SLL barrel shifter between two requesters.
// Operands are registered, the shifter settles for SETTLE_CYCLES, and the result is held until consumed.
module shift_arbiter_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic [31:0]      sh_dataA,
  output logic [31:0]      sh_dataB,
  output logic [5:0]       sh_signal,
  input  logic [31:0]      sh_dataOut,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic             rsp_oor,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_id;
  logic        last_grant;
  logic [3:0]  settle_cnt;
  logic        grant0;
  logic        grant1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Ready never depends on the payload; requesters hold valid and a/b until ready.
  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign sh_dataA   = op_a;
  assign sh_dataB   = op_b;
  // All-ones is a non-shift opcode that forces the shifter output to zero.
  assign sh_signal  = (state == SHIFT) ? 6'b000000 : 6'b111111;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_id     <= 1'b0;
      rsp_oor    <= 1'b0;
      done_count <= '0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      settle_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_a       <= grant1 ? req1_a : req0_a;
            op_b       <= grant1 ? req1_b : req0_b;
            op_id      <= grant1;
            last_grant <= grant1;
            settle_cnt <= 4'd0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (settle_cnt == SETTLE_LAST) begin
            rsp_data  <= sh_dataOut;
            rsp_id    <= op_id;
            rsp_oor   <= |op_b[31:5];
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RESP: begin
          // Response fields stay as they are after consumption; only valid drops.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            done_count <= done_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl: a default instance plus a CNT_W=4, SETTLE_CYCLES=3 instance.
// A behavioural SLL shifter model sits on each instance's shifter port.
module tb_shift_arbiter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] sh_dataA, sh_dataB, sh_dataOut;
  logic [5:0]  sh_signal;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_oor, busy;
  logic [31:0] rsp_data;
  logic [15:0] done_count;

  logic        w_req0_valid, w_req0_ready, w_req1_valid, w_req1_ready;
  logic [31:0] w_req0_a, w_req0_b, w_req1_a, w_req1_b;
  logic [31:0] w_sh_dataA, w_sh_dataB, w_sh_dataOut;
  logic [5:0]  w_sh_signal;
  logic        w_rsp_valid, w_rsp_ready, w_rsp_id, w_rsp_oor, w_busy;
  logic [31:0] w_rsp_data;
  logic [3:0]  w_done_count;

  shift_arbiter_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .sh_dataA(sh_dataA), .sh_dataB(sh_dataB), .sh_signal(sh_signal), .sh_dataOut(sh_dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_oor(rsp_oor), .busy(busy), .done_count(done_count)
  );

  shift_arbiter_ctrl #(.SETTLE_CYCLES(3), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(w_req0_valid), .req0_ready(w_req0_ready), .req0_a(w_req0_a), .req0_b(w_req0_b),
    .req1_valid(w_req1_valid), .req1_ready(w_req1_ready), .req1_a(w_req1_a), .req1_b(w_req1_b),
    .sh_dataA(w_sh_dataA), .sh_dataB(w_sh_dataB), .sh_signal(w_sh_signal), .sh_dataOut(w_sh_dataOut),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data), .rsp_id(w_rsp_id),
    .rsp_oor(w_rsp_oor), .busy(w_busy), .done_count(w_done_count)
  );

  // Shifter model: SLL when Signal is zero and the amount is in range, zero otherwise.
  always_comb begin
    sh_dataOut = 32'd0;
    if (sh_signal == 6'b000000 && sh_dataB[31:5] == 27'd0) sh_dataOut = sh_dataA << sh_dataB[4:0];
    w_sh_dataOut = 32'd0;
    if (w_sh_signal == 6'b000000 && w_sh_dataB[31:5] == 27'd0) w_sh_dataOut = w_sh_dataA << w_sh_dataB[4:0];
  end

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_oor;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on the default instance with rsp_ready raised once the response is up.
  task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_data, input logic exp_oor, input string name);
    int n;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    check({name, " grant"}, 32'(n < 20), 32'd1);
    check({name, " other_ready"}, id ? req0_ready : req1_ready, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({name, " sh_signal"}, sh_signal, 32'h00);
    check({name, " sh_dataA"}, sh_dataA, a);
    check({name, " sh_dataB"}, sh_dataB, b);
    check({name, " busy"}, busy, 32'd1);
    n = 1;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check({name, " latency"}, n, 32'd2);
    check({name, " rsp_data"}, rsp_data, exp_data);
    check({name, " rsp_id"}, rsp_id, id);
    check({name, " rsp_oor"}, rsp_oor, exp_oor);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_done++;
    check({name, " consumed"}, rsp_valid, 32'd0);
    check({name, " done_count"}, done_count, exp_done);
    check({name, " idle_signal"}, sh_signal, 32'h3F);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int grants;
    int resps;
    logic [31:0] e;

    vecs[0] = '{1'b0, 32'h0000_0001, 32'd5,          32'h0000_0020, 1'b0};
    vecs[1] = '{1'b1, 32'h1234_5678, 32'h0000_0020,  32'h0000_0000, 1'b1};
    vecs[2] = '{1'b1, 32'hA5A5_A5A5, 32'd0,          32'hA5A5_A5A5, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0001, 32'd31,         32'h8000_0000, 1'b0};
    vecs[4] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0100,  32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0F0F_0F0F, 32'd8,          32'h0F0F_0F00, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0003,  32'h0000_0000, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b0;
    w_req0_valid = 1'b0; w_req0_a = '0; w_req0_b = '0;
    w_req1_valid = 1'b0; w_req1_a = '0; w_req1_b = '0;
    w_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst busy", busy, 32'd0);
    check("rst rsp_valid", rsp_valid, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_id", rsp_id, 32'd0);
    check("rst rsp_oor", rsp_oor, 32'd0);
    check("rst done_count", done_count, 32'd0);
    check("rst sh_dataA", sh_dataA, 32'd0);
    check("rst sh_dataB", sh_dataB, 32'd0);
    check("rst sh_signal", sh_signal, 32'h3F);
    check("rst ready0", req0_ready, 32'd0);
    check("rst w_done_count", w_done_count, 32'd0);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_oor, $sformatf("vec%0d", i));

    // Backpressure: response held for 10 cycles while req0 waits.
    req1_valid = 1'b1; req1_a = 32'h0000_00FF; req1_b = 32'd4;
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin tick(); n++; end
    check("bp grant", 32'(n < 20), 32'd1);
    tick();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("bp rsp_valid", rsp_valid, 32'd1);
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp held valid", rsp_valid, 32'd1);
      check("bp held data", rsp_data, 32'h0000_0FF0);
      check("bp held id", rsp_id, 32'd1);
      check("bp held oor", rsp_oor, 32'd0);
      check("bp ready0", req0_ready, 32'd0);
      check("bp ready1", req1_ready, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_done++;
    check("bp consumed", rsp_valid, 32'd0);
    check("bp done_count", done_count, exp_done);
    check("bp data kept", rsp_data, 32'h0000_0FF0);
    check("bp id kept", rsp_id, 32'd1);
    check("bp ready reasserts", req0_ready, 32'd1);
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check("bp second data", rsp_data, 32'h0000_000C);
    check("bp second id", rsp_id, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_done++;
    check("bp second done", done_count, exp_done);

    // Reset while an operation is in SHIFT.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin tick(); n++; end
    tick();
    req0_valid = 1'b0;
    check("midrst busy before", busy, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_done = 0;
    check("midrst busy", busy, 32'd0);
    check("midrst rsp_valid", rsp_valid, 32'd0);
    check("midrst done_count", done_count, 32'd0);
    check("midrst rsp_data", rsp_data, 32'd0);

    // Tie and round-robin with both requesters held valid.
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = 32'h8000_0001; req1_b = 32'd31;
    rsp_ready = 1'b1;
    #1;
    check("tie ready0", req0_ready, 32'd1);
    check("tie ready1", req1_ready, 32'd0);
    grants = 0;
    resps = 0;
    for (int c = 0; c < 60; c++) begin
      check("rr one_ready", 32'(req0_ready && req1_ready), 32'd0);
      if ((req0_ready || req1_ready) && grants < 4) begin
        check($sformatf("rr grant%0d id", grants), req1_ready, 32'(grants % 2));
        exp_q.push_back((grants % 2 == 0) ? 32'hFFFF_FFF0 : 32'h8000_0000);
        grants++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rr unexpected rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rr rsp%0d data", resps), rsp_data, e);
          check($sformatf("rr rsp%0d id", resps), rsp_id, 32'(resps % 2));
          check($sformatf("rr rsp%0d oor", resps), rsp_oor, 32'd0);
        end
        resps++;
        if (resps == 4) break;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr responses", resps, 32'd4);
    tick();
    rsp_ready = 1'b0;
    check("rr done_count", done_count, 32'd4);

    // Counter wrap and longer settle on the narrow instance.
    w_rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      w_req0_valid = 1'b1; w_req0_a = 32'(i + 1); w_req0_b = 32'd1;
      #1;
      n = 0;
      while (!w_req0_ready && n < 20) begin tick(); n++; end
      check($sformatf("wrap op%0d grant", i), 32'(n < 20), 32'd1);
      tick();
      w_req0_valid = 1'b0;
      n = 1;
      while (!w_rsp_valid && n < 30) begin tick(); n++; end
      check($sformatf("wrap op%0d latency", i), n, 32'd4);
      check($sformatf("wrap op%0d data", i), w_rsp_data, 32'(2 * (i + 1)));
      check($sformatf("wrap op%0d id", i), w_rsp_id, 32'd0);
      check($sformatf("wrap op%0d oor", i), w_rsp_oor, 32'd0);
      tick();
      check($sformatf("wrap op%0d consumed", i), w_rsp_valid, 32'd0);
      if (i == 15) check("wrap at 16", w_done_count, 32'd0);
    end
    check("wrap final done_count", w_done_count, 32'd1);
    check("wrap idle", w_busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
